mc_sequencer: RTL
=================

MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 SHALL have clk, input, 1, sole clock; all state changes on its rising edge.
REQ-002 SHALL have rst, input, 1, reset, asynchronous and active-high.
REQ-003 SHALL have instr, input, 32, instruction register contents; valid from DECODE onward.
REQ-004 SHALL have EQ, input, 1, ALU zero/equal flag.
REQ-005 SHALL have mem_ready, input, 1, memory accepts or returns data this cycle.
REQ-006 SHALL have mem_req, output, 1, memory access request.
REQ-007 SHALL have mem_we, output, 1, write qualifier for mem_req.
REQ-008 SHALL have IorD, output, 1: 0 = address from PC, 1 = address from ALUout.
REQ-009 SHALL have IRWrite, output, 1, load instruction register.
REQ-010 SHALL have PCWrite, output, 1, PC update enable.
REQ-011 SHALL have PCsrc, output, 1: 0 = PC+4, 1 = PC+Imm.
REQ-012 SHALL have RegWrite, output, 1, register-file write enable.
REQ-013 SHALL have ALUctrl, output, 3: 000 add, 001 sub, 010 and, 011 or.
REQ-014 SHALL have ALUsrc, output, 1: 0 = read2, 1 = Imm.
REQ-015 SHALL have ImmSrc, output, 2: 00 I-type, 01 S-type, 10 B-type.
REQ-016 SHALL have ResultSrc, output, 1: 0 = ALUout, 1 = memory read data.
REQ-017 SHALL have halted, output, 1, illegal instruction seen.
REQ-018 SHALL have instret, output, 32, retired-instruction count.
REQ-019 SHALL have wait_cycles, output, 16, memory stall-cycle count.

Function
REQ-020 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-021 SHALL move IDLE->FETCH unconditionally after one cycle; all outputs 0 in IDLE.
REQ-022 FETCH SHALL drive mem_req=1, mem_we=0, IorD=0; hold until mem_ready=1, then IRWrite=1 that cycle and go to DECODE.
REQ-023 DECODE SHALL take one cycle and classify opcode: 0110011 R (funct7[5]/funct3 select add/sub/and/or), 0010011 addi, 0000011 lw, 0100011 sw, 1100011 beq/bne; any other opcode or funct goes to HALT.
REQ-024 EXEC SHALL drive ALUctrl/ALUsrc/ImmSrc per class: R ALUsrc=0; addi/lw ALUsrc=1 ImmSrc=00 add; sw ALUsrc=1 ImmSrc=01 add; branch ALUsrc=0 ImmSrc=10 sub.
REQ-025 From EXEC, R/addi SHALL go to WB, lw/sw to MEM, and branch SHALL retire in EXEC with PCsrc = (funct3==000 ? EQ : !EQ).
REQ-026 MEM SHALL drive mem_req=1, IorD=1, mem_we=1 for sw (0 for lw), hold until mem_ready=1; sw then retires, lw goes to WB.
REQ-027 WB SHALL drive RegWrite=1 for exactly one cycle, with ResultSrc=1 for lw and 0 otherwise, then retire.
REQ-028 Retire SHALL mean PCWrite=1 for exactly one cycle, instret+1 (wrapping 0xFFFFFFFF->0), and next state FETCH; PCsrc=0 except on a taken branch.
REQ-029 Zero-wait latency SHALL be: branch 3 cycles, R/addi/sw 4 cycles, lw 5 cycles, counted FETCH to retire inclusive.
REQ-030 wait_cycles SHALL increment on every cycle with mem_req=1 and mem_ready=0, saturating at 0xFFFF.
REQ-031 HALT SHALL be absorbing: halted=1, all other controls 0, counters frozen, exit only via rst.
REQ-032 mem_ready while mem_req=0 SHALL be ignored.
REQ-033 rd=x0 SHALL NOT be special-cased; the register file discards the write.

Reset
REQ-034 rst SHALL immediately force state IDLE, instret=0, wait_cycles=0, and all control outputs and halted to 0, including mid-access, without waiting for mem_ready.

Structure
REQ-035 State enum, ALUctrl codes, ImmSrc codes, and opcode constants SHALL live in shared package mc_pkg.
REQ-036 Instruction classification SHALL be one combinational sub-module, mc_decode (instr -> class and illegal flag); the FSM and counters SHALL stay in mc_sequencer.

Verification
REQ-037 add x3,x1,x2 with mem_ready tied 1 -> IRWrite at cycle 1, ALUctrl=000 and ALUsrc=0 in EXEC, RegWrite then PCWrite at cycle 4, instret=1.
REQ-038 lw with mem_ready low for 3 FETCH cycles and 2 MEM cycles -> wait_cycles=5, ResultSrc=1 in WB, retire 10 cycles after FETCH entry.
REQ-039 beq with EQ=1, then bne with EQ=1 -> PCsrc=1 with PCWrite for the first, PCsrc=0 with PCWrite for the second; RegWrite never asserted.
REQ-040 sw with 2-cycle MEM wait -> mem_we=1 and IorD=1 throughout MEM, PCWrite on the mem_ready cycle, no WB state.
REQ-041 opcode 1111111 -> HALT after DECODE, halted=1, mem_req=0 for 20 cycles, instret unchanged.
REQ-042 rst asserted mid-MEM while mem_ready=0 -> all outputs 0 asynchronously, counters 0, FETCH reached 2 cycles after release.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle sequencer: FSM states, ALU and
// immediate-format codes, opcode/funct constants and the decoded-class record.
package mc_pkg;

    // Sequencer states; explicit encodings keep waveform values stable
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    // ALUctrl codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    // ImmSrc codes
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    // Opcodes
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_ADDI   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // funct3 values accepted per opcode
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_ADDI    = 3'b000;
    localparam logic [2:0] F3_LW      = 3'b010;
    localparam logic [2:0] F3_SW      = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;

    // funct7 values accepted for R-type
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Instruction classes that steer the EXEC/MEM/WB path
    typedef enum logic [2:0] {
        CL_R    = 3'd0,
        CL_ADDI = 3'd1,
        CL_LW   = 3'd2,
        CL_SW   = 3'd3,
        CL_BR   = 3'd4
    } iclass_t;

    // Decoded instruction: class, ALU operation, and branch sense
    typedef struct packed {
        iclass_t    cls;
        logic [2:0] alu;
        logic       br_ne;
    } dec_t;

    localparam dec_t DEC_NOP = '{cls: CL_R, alu: ALU_ADD, br_ne: 1'b0};

    // Branch resolution: beq takes on EQ, bne takes on !EQ
    function automatic logic branch_taken(input logic br_ne, input logic eq);
        return br_ne ? ~eq : eq;
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct3/funct7 -> class,
// ALU operation and illegal flag. Any unsupported encoding is illegal.
module mc_decode
    import mc_pkg::*;
(
    input  logic [31:0] instr_i,
    output dec_t        dec_o,
    output logic        illegal_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    // Register and immediate fields play no part in classification
    logic unused_fields;
    assign unused_fields = ^{instr_i[24:15], instr_i[11:7]};

    // Classify the instruction and flag anything outside the supported set
    always_comb begin
        dec_o     = DEC_NOP;
        illegal_o = 1'b0;
        case (opcode)
            OP_R: begin
                dec_o.cls = CL_R;
                case (funct3)
                    F3_ADD_SUB: begin
                        if (funct7 == F7_BASE) begin
                            dec_o.alu = ALU_ADD;
                        end else if (funct7 == F7_ALT) begin
                            dec_o.alu = ALU_SUB;
                        end else begin
                            illegal_o = 1'b1;
                        end
                    end
                    F3_AND: begin
                        dec_o.alu = ALU_AND;
                        illegal_o = (funct7 != F7_BASE);
                    end
                    F3_OR: begin
                        dec_o.alu = ALU_OR;
                        illegal_o = (funct7 != F7_BASE);
                    end
                    default: illegal_o = 1'b1;
                endcase
            end
            OP_ADDI: begin
                dec_o.cls = CL_ADDI;
                illegal_o = (funct3 != F3_ADDI);
            end
            OP_LOAD: begin
                dec_o.cls = CL_LW;
                illegal_o = (funct3 != F3_LW);
            end
            OP_STORE: begin
                dec_o.cls = CL_SW;
                illegal_o = (funct3 != F3_SW);
            end
            OP_BRANCH: begin
                dec_o.cls = CL_BR;
                dec_o.alu = ALU_SUB;
                if (funct3 == F3_BEQ) begin
                    dec_o.br_ne = 1'b0;
                end else if (funct3 == F3_BNE) begin
                    dec_o.br_ne = 1'b1;
                end else begin
                    illegal_o = 1'b1;
                end
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB FSM driving the
// datapath controls, plus retired-instruction and memory-stall counters.
module mc_sequencer
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        EQ,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        IorD,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        PCsrc,
    output logic        RegWrite,
    output logic [2:0]  ALUctrl,
    output logic        ALUsrc,
    output logic [1:0]  ImmSrc,
    output logic        ResultSrc,
    output logic        halted,
    output logic [31:0] instret,
    output logic [15:0] wait_cycles
);

    state_t      state_q, state_d;
    dec_t        dec_q, dec_d;
    dec_t        dec_w;
    logic        illegal_w;
    logic [31:0] instret_q, instret_d;
    logic [15:0] wait_q, wait_d;

    mc_decode u_decode (
        .instr_i   (instr),
        .dec_o     (dec_w),
        .illegal_o (illegal_w)
    );

    // Capture the classification during DECODE so later states do not
    // depend on instr staying stable past that point
    assign dec_d = (state_q == ST_DECODE) ? dec_w : dec_q;

    // Next-state and control outputs; every output is zero unless a state
    // drives it, so IDLE and reset yield all-zero controls
    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        IorD      = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        PCsrc     = 1'b0;
        RegWrite  = 1'b0;
        ALUctrl   = ALU_ADD;
        ALUsrc    = 1'b0;
        ImmSrc    = IMM_I;
        ResultSrc = 1'b0;
        halted    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = illegal_w ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                case (dec_q.cls)
                    CL_R: begin
                        ALUctrl = dec_q.alu;
                        ALUsrc  = 1'b0;
                        state_d = ST_WB;
                    end
                    CL_ADDI: begin
                        ALUctrl = ALU_ADD;
                        ALUsrc  = 1'b1;
                        ImmSrc  = IMM_I;
                        state_d = ST_WB;
                    end
                    CL_LW: begin
                        ALUctrl = ALU_ADD;
                        ALUsrc  = 1'b1;
                        ImmSrc  = IMM_I;
                        state_d = ST_MEM;
                    end
                    CL_SW: begin
                        ALUctrl = ALU_ADD;
                        ALUsrc  = 1'b1;
                        ImmSrc  = IMM_S;
                        state_d = ST_MEM;
                    end
                    CL_BR: begin
                        ALUctrl = ALU_SUB;
                        ALUsrc  = 1'b0;
                        ImmSrc  = IMM_B;
                        PCWrite = 1'b1;
                        PCsrc   = branch_taken(dec_q.br_ne, EQ);
                        state_d = ST_FETCH;
                    end
                    default: state_d = ST_HALT;
                endcase
            end
            ST_MEM: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
                mem_we  = (dec_q.cls == CL_SW);
                if (mem_ready) begin
                    if (dec_q.cls == CL_SW) begin
                        PCWrite = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                RegWrite  = 1'b1;
                ResultSrc = (dec_q.cls == CL_LW);
                PCWrite   = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Counter updates: retire is exactly the PCWrite cycle; stalls count
    // requested-but-not-ready cycles and stick at all-ones
    always_comb begin
        instret_d = instret_q;
        wait_d    = wait_q;
        if (PCWrite) begin
            instret_d = instret_q + 32'd1;
        end
        if (mem_req && !mem_ready && (wait_q != '1)) begin
            wait_d = wait_q + 16'd1;
        end
    end

    // State and counter registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            dec_q     <= DEC_NOP;
            instret_q <= '0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            dec_q     <= dec_d;
            instret_q <= instret_d;
            wait_q    <= wait_d;
        end
    end

    assign instret     = instret_q;
    assign wait_cycles = wait_q;

endmodule
